// File: rtl/mul_div_unit.sv
// Iterative 32x32 multiply / 32/32 divide unit that owns the HI/LO register pair.
// One shift-add or restoring-divide step per cycle; every operation takes 33 cycles.
module mul_div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        mthi_i,
    input  logic        mtlo_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam logic [1:0] OP_MULT = 2'b00;

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic [1:0]  op_q;
    logic [31:0] opnd_q;
    logic [63:0] work_q;
    logic        res_neg_q;
    logic        a_neg_q;
    logic        dbz_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        done_q;

    // Operand conditioning at accept: signed ops (op[0]==0) run on magnitudes.
    logic        is_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;

    assign is_signed = ~op_i[0];
    assign a_neg     = is_signed & a_i[31];
    assign b_neg     = is_signed & b_i[31];
    assign a_mag     = a_neg ? (32'd0 - a_i) : a_i;
    assign b_mag     = b_neg ? (32'd0 - b_i) : b_i;

    // work_q holds {partial product, multiplier} or {remainder, dividend/quotient}.
    logic [32:0] mul_sum;
    logic [63:0] work_mul_d;
    logic [32:0] div_part;
    logic        div_ge;
    logic [31:0] rem_d;
    logic [63:0] work_div_d;

    assign mul_sum    = {1'b0, work_q[63:32]} + (work_q[0] ? {1'b0, opnd_q} : 33'd0);
    assign work_mul_d = {mul_sum, work_q[31:1]};

    assign div_part   = work_q[63:31];
    assign div_ge     = div_part >= {1'b0, opnd_q};
    assign rem_d      = div_ge ? (div_part[31:0] - opnd_q) : div_part[31:0];
    assign work_div_d = {rem_d, work_q[30:0], div_ge};

    // Sign fix-up. With a zero divisor the remainder ends up holding |a|, so
    // re-applying the dividend sign restores the original a for HI.
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    assign prod_fix = res_neg_q ? (64'd0 - work_q) : work_q;
    assign quo_fix  = res_neg_q ? (32'd0 - work_q[31:0]) : work_q[31:0];
    assign rem_fix  = a_neg_q ? (32'd0 - work_q[63:32]) : work_q[63:32];

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 5'd0;
            op_q      <= 2'd0;
            opnd_q    <= 32'd0;
            work_q    <= 64'd0;
            res_neg_q <= 1'b0;
            a_neg_q   <= 1'b0;
            dbz_q     <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mthi_i) hi_q <= wdata_i;
                    if (mtlo_i) lo_q <= wdata_i;
                    if (start_i) begin
                        op_q      <= op_i;
                        opnd_q    <= b_mag;
                        work_q    <= {32'd0, a_mag};
                        res_neg_q <= a_neg ^ b_neg;
                        a_neg_q   <= a_neg;
                        dbz_q     <= (b_i == 32'd0);
                        cnt_q     <= 5'd0;
                        state_q   <= CALC;
                    end
                end
                CALC: begin
                    work_q <= op_q[1] ? work_div_d : work_mul_d;
                    cnt_q  <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) state_q <= FIX;
                end
                FIX: begin
                    if (!op_q[1]) begin
                        hi_q <= (op_q == OP_MULT) ? prod_fix[63:32] : work_q[63:32];
                        lo_q <= (op_q == OP_MULT) ? prod_fix[31:0]  : work_q[31:0];
                    end else if (dbz_q) begin
                        hi_q <= rem_fix;
                        lo_q <= 32'hFFFF_FFFF;
                    end else begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o = (state_q != IDLE);
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: stimulus pushes expected {HI,LO}, a monitor
// pops and compares on every done pulse; randomized ops use a plain-arithmetic model.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          total = 0;
    int          bad   = 0;
    logic [63:0] exp_q[$];

    mul_div_unit dut (
        .clk    (clk),
        .rst    (rst),
        .start_i(start),
        .op_i   (op),
        .a_i    (a),
        .b_i    (b),
        .mthi_i (mthi),
        .mtlo_i (mtlo),
        .wdata_i(wdata),
        .busy_o (busy),
        .done_o (done),
        .hi_o   (hi),
        .lo_o   (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, wanted %h", name, act, req);
        end
    endtask

    // Reference: full-width arithmetic; SV / and % truncate toward zero with the dividend's sign.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x,
                                          input logic [31:0] y);
        longint      sx;
        longint      sy;
        longint      q;
        longint      r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        q  = 0;
        r  = 0;
        case (o)
            2'd0:    p = sx * sy;
            2'd1:    p = {32'd0, x} * {32'd0, y};
            default: begin
                if (y == 32'd0) begin
                    p = {x, 32'hFFFF_FFFF};
                end else begin
                    if (o == 2'd2) begin
                        q = sx / sy;
                        r = sx % sy;
                    end else begin
                        q = longint'({32'd0, x}) / longint'({32'd0, y});
                        r = longint'({32'd0, x}) % longint'({32'd0, y});
                    end
                    p = {r[31:0], q[31:0]};
                end
            end
        endcase
        return p;
    endfunction

    always @(negedge clk) begin
        if (rst === 1'b0 && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got hi=%h lo=%h, wanted no result", hi, lo);
            end else begin
                check("result", {hi, lo}, exp_q.pop_front());
            end
        end
    end

    // Called just after an accept edge; returns at the negedge after the FIX edge.
    task automatic wait_done();
        int cycles;
        cycles = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (busy) cycles++;
            else break;
        end
        check("busy_cycles", 64'(cycles), 64'd33);
        check("done_high", {63'd0, done}, 64'd1);
        @(negedge clk);
        check("done_low", {63'd0, done}, 64'd0);
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [63:0] e);
        @(negedge clk);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 2'($urandom_range(3));
        a     = $urandom;
        b     = $urandom;
        wait_done();
    endtask

    task automatic write_hilo(input logic wh, input logic wl, input logic [31:0] v);
        @(negedge clk);
        mthi  = wh;
        mtlo  = wl;
        wdata = v;
        @(posedge clk);
        #1;
        mthi = 1'b0;
        mtlo = 1'b0;
    endtask

    initial begin
        int          cnt;
        logic [1:0]  ro;
        logic [31:0] rx;
        logic [31:0] ry;

        rst   = 1'b1;
        start = 1'b0;
        op    = 2'd0;
        a     = 32'd0;
        b     = 32'd0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_hilo", {hi, lo}, 64'd0);
        check("reset_busy_done", {62'd0, busy, done}, 64'd0);

        write_hilo(1'b1, 1'b1, 32'h1234_5678);
        check("mthi_mtlo_same_cycle", {hi, lo}, {32'h1234_5678, 32'h1234_5678});

        issue(2'd0, 32'hFFFF_FFFF, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFE});
        issue(2'd1, 32'hFFFF_FFFF, 32'd2, {32'h0000_0001, 32'hFFFF_FFFE});
        issue(2'd2, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000});
        issue(2'd3, 32'd7, 32'd0, {32'd7, 32'hFFFF_FFFF});
        issue(2'd2, 32'hFFFF_FFF9, 32'd0, {32'hFFFF_FFF9, 32'hFFFF_FFFF});

        // Held start: MTHI during CALC and operand changes mid-op must be ignored.
        write_hilo(1'b1, 1'b1, 32'hA5A5_A5A5);
        @(negedge clk);
        op    = 2'd1;
        a     = 32'd3;
        b     = 32'd5;
        start = 1'b1;
        exp_q.push_back({32'd0, 32'd15});
        @(posedge clk);
        #1;
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!busy) break;
            cnt++;
            if (cnt == 5) begin
                mthi  = 1'b1;
                wdata = 32'hDEAD_BEEF;
            end
            if (cnt == 6) begin
                mthi = 1'b0;
                check("mthi_in_calc_ignored", {32'd0, hi}, {32'd0, 32'hA5A5_A5A5});
            end
            if (cnt == 10) begin
                a = 32'd7;
                b = 32'd9;
            end
        end
        check("held_busy_cycles", 64'(cnt), 64'd33);
        exp_q.push_back({32'd0, 32'd63});
        @(posedge clk);
        #1;
        check("b2b_accept_e34", {63'd0, busy}, 64'd1);
        start = 1'b0;
        wait_done();

        // MTLO together with an accepted start.
        write_hilo(1'b1, 1'b1, 32'h0);
        @(negedge clk);
        op    = 2'd1;
        a     = 32'd2;
        b     = 32'd3;
        start = 1'b1;
        mtlo  = 1'b1;
        wdata = 32'h1234_5678;
        exp_q.push_back({32'd0, 32'd6});
        @(posedge clk);
        #1;
        start = 1'b0;
        mtlo  = 1'b0;
        check("mtlo_with_start", {hi, lo}, {32'd0, 32'h1234_5678});
        wait_done();

        // Reset mid-operation.
        @(negedge clk);
        op    = 2'd3;
        a     = 32'd100;
        b     = 32'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midop_reset_hilo", {hi, lo}, 64'd0);
        check("midop_reset_busy_done", {62'd0, busy, done}, 64'd0);
        issue(2'd3, 32'd100, 32'd7, {32'd2, 32'd14});

        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(3));
            rx = ($urandom_range(3) == 0) ? 32'($urandom_range(200)) : $urandom;
            case ($urandom_range(4))
                0:       ry = 32'd0;
                1:       ry = 32'($urandom_range(1, 9));
                2:       ry = 32'hFFFF_FFFF - 32'($urandom_range(5));
                default: ry = $urandom;
            endcase
            issue(ro, rx, ry, model(ro, rx, ry));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative multiply/divide unit owning the HI/LO registers for MULT, MULTU, DIV, DIVU, MTHI, MTLO and supplying HI/LO for MFHI/MFLO. Sits beside the ALU in the execute stage. It consumes the two register-file read operands and feeds HI/LO back toward the register-file write port through the writeback mux. Operations take a fixed 33 cycles; the pipeline stalls on `busy`.

## Interface
- No parameters. Data width is fixed at 32, and HI/LO is 64 bits total.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  request an operation; sampled only in IDLE.
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with `start`.
- `a`  in  32  rs operand (multiplicand / dividend); sampled with `start`.
- `b`  in  32  rt operand (multiplier / divisor); sampled with `start`.
- `mthi`  in  1  write `wdata` into HI.
- `mtlo`  in  1  write `wdata` into LO.
- `wdata`  in  32  MTHI/MTLO data.
- `busy`  out  1  high while state is not IDLE; combinational from state.
- `done`  out  1  one-cycle pulse when HI/LO receive a result.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- **States.**
  - IDLE: `start` leads to CALC.
  - CALC: runs 32 iterations, with a 5-bit counter going 0..31. After iteration 31 it moves to FIX.
  - FIX: unconditionally returns to IDLE.
- **Accept.** On an edge in IDLE with `start=1`:
  - Latch `op`.
  - For signed ops, latch the magnitudes |a| and |b|, and record the result sign and dividend sign.
  - For unsigned ops, latch raw `a` and `b`.
  - Clear the counter.
- **Multiply.** Shift-add over 32 iterations produces an unsigned 64-bit product.
  - In FIX, MULT negates the product (two's complement, 64-bit) if exactly one operand was negative.
  - HI gets product[63:32]; LO gets product[31:0].
- **Divide.** Restoring division, one quotient bit per iteration, produces quotient Q and remainder R.
  - In FIX, DIV negates Q if the operand signs differ, and negates R if the dividend was negative.
  - Quotient truncates toward zero; the remainder takes the dividend's sign.
  - LO gets Q; HI gets R.
- **Divide by zero (b=0), DIV or DIVU.** LO=32'hFFFFFFFF and HI=`a` (original value), with no sign fix.
- **DIV 0x80000000 / 0xFFFFFFFF.** LO=0x80000000, HI=0. This falls out of the magnitude algorithm with no special case.
- **MTHI/MTLO.**
  - Honoured only in IDLE and ignored otherwise, including during FIX.
  - Both may assert in the same cycle.
  - If asserted together with an accepted `start`, the write still takes effect; the operation result later overwrites HI/LO.
- **Start outside IDLE.** `start` in CALC or FIX is ignored: no queueing, no error.
- **Operand stability.** `a`, `b` and `op` are don't-care after the accept edge.

## Timing
- **Reset values.** `hi`=0, `lo`=0, `done`=0, `busy`=0, state IDLE, counter 0.
- **Reset mid-operation.** Aborts immediately at the edge and produces all reset values; no partial HI/LO update.
- **Cycle sequence.** Let E0 be the accept edge.
  - After E0: `busy`=1.
  - Edges E1..E32: one iteration each.
  - After E32: state FIX.
  - Edge E33: HI/LO written, `done`=1, state IDLE, so `busy`=0 after E33.
  - Edge E34: `done` returns to 0.
- **Latency.** Result visible on `hi`/`lo` 33 cycles after the accept edge.
- **Back-to-back.** The earliest next accept is E34, the first IDLE-sampled edge after E33. A `start` held high continuously therefore produces an accept every 34 cycles.
- **Forwarding.** `hi`/`lo` are registered outputs and never forwarded combinationally. An MFHI/MFLO issued while `busy`=1 must be stalled by the pipeline.
- **MTHI/MTLO latency.** New value visible on `hi`/`lo` the cycle after the write edge.

## Test plan
- **MULT / MULTU.**
  - MULT a=0xFFFFFFFF, b=2 -> after 33 cycles HI=0xFFFFFFFF, LO=0xFFFFFFFE, `done` pulses 1 cycle.
  - MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- **Signed division.**
  - DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
  - DIV a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0.
- **Divide by zero.**
  - DIVU a=7, b=0 -> LO=0xFFFFFFFF, HI=7.
  - DIV a=0xFFFFFFF9, b=0 -> LO=0xFFFFFFFF, HI=0xFFFFFFF9.
- **Busy and back-to-back.**
  - Hold `start`=1 with MULTU 3*5 -> `busy` high exactly 33 cycles.
  - Second `start` at cycle 10 is ignored.
  - Second operation accepted at E34.
  - `mthi`=1, `wdata`=0xDEADBEEF during CALC -> HI unchanged.
- **Reset mid-operation.** Start DIVU 100/7, assert `rst` at cycle 10 -> next cycle `busy`=0, `done`=0, HI=LO=0; a subsequent DIVU 100/7 gives LO=14, HI=2.
- **MTHI/MTLO in IDLE.**
  - Same-cycle `mthi`+`mtlo` with `wdata`=0x12345678 in IDLE -> HI=LO=0x12345678 next cycle.
  - `mtlo` together with accepted MULTU 2*3 -> LO=0x12345678 is immediately visible, then LO=6 and HI=0 at E33.
